uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- Byte-wide UART transmitter for 8 data bits, no parity, 1 or 2 stop bits, LSB first. It is the transmit-side counterpart of the project's UART receiver.
- Accepts bytes over a valid/ready handshake into a small FIFO. Serialises them onto tx at CLK_HZ/BAUD clocks per bit.
- Sits between the host-side command/response logic and the board TX pin.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency in Hz.
- BAUD, 115200, line rate in bit/s. DIV = CLK_HZ/BAUD clocks per bit (integer divide, 434 at defaults). DIV >= 2 required.
- STOP_BITS, 1, number of stop bits. Only 1 or 2 are legal; elaboration error otherwise.
- FIFO_DEPTH, 4, input FIFO entries. Power of two, >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- data  input  8  byte to transmit.
- valid  input  1  data is valid this cycle.
- ready  output  1  FIFO can accept a byte. Equals !full.
- tx  output  1  serial line, idle high, registered.
- busy  output  1  high while a frame is in progress or the FIFO is non-empty.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high (rst). All state registers reset asynchronously.
- Reset values: tx=1, busy=0, ready=1. FIFO empty, state IDLE, counters 0.
- Writes during reset: valid is ignored while rst=1.
- Handshake:
  - A byte is accepted on a rising edge where valid && ready.
  - data is sampled at that edge.
  - valid may be held high across multiple accepts (one byte per edge).
  - When full, ready=0 and writes are dropped. Upstream must hold the byte.
- FIFO:
  - Synchronous, first-word fall-through not required.
  - Push and pop on the same edge (not full, not empty): both occur, occupancy unchanged.
  - Pointers wrap modulo FIFO_DEPTH. Full/empty are distinguished by an extra pointer bit or an occupancy counter.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if FIFO non-empty, pop into shift register, tx<=0, cnt<=DIV-1, go to START.
  - START: when cnt==0, tx<=sh[0], shift right, bitp<=0, cnt<=DIV-1, go to DATA. Otherwise decrement cnt.
  - DATA: when cnt==0:
    - If bitp==7: tx<=1, cnt<=DIV-1, stopn<=0, go to STOP.
    - Otherwise tx<=sh[0], shift, bitp++, cnt<=DIV-1.
  - STOP: when cnt==0:
    - If stopn < STOP_BITS-1: stopn++, cnt<=DIV-1.
    - Else if FIFO non-empty: pop, tx<=0, cnt<=DIV-1, go to START (back-to-back, zero idle gap).
    - Else go to IDLE, tx stays 1.
- Timing:
  - Every bit is exactly DIV clocks.
  - Frame length is (9+STOP_BITS)*DIV clocks.
  - Latency: byte accepted at edge N into empty FIFO while IDLE → tx falls after edge N+1.
- Baud counter: restarts on every bit load; it is not free-running. Width is $clog2(DIV).
- busy = (state!=IDLE) || !empty. busy falls in the same cycle the FSM enters IDLE with an empty FIFO.
- Reset mid-frame: tx returns to 1 immediately (asynchronous), frame aborted, FIFO contents discarded.
- tx is glitch-free: driven only from a flop.

Decomposition:
- Package uart_pkg:
  - tx/rx FSM state enum.
  - UART_DATA_BITS=8.
  - Function uart_div(clk_hz, baud) returning clocks per bit.
  - uart_tx and the existing receiver both import it.
- Sub-module uart_tx_fifo:
  - Parameterised by width and depth.
  - Ports: push/pop/din/dout/full/empty.
  - Instantiated once inside uart_tx.
- The FSM and baud counter stay in uart_tx.

Test Plan:
- Reset then idle: rst high 3 cycles, then 2000 cycles with valid=0 → tx=1, busy=0, ready=1 throughout.
- Single byte 0x55 at defaults → after edge N+1, tx reads 0 for 434 clocks, then 1,0,1,0,1,0,1,0 at 434 clocks each, then 1 for 434. busy falls 4340 clocks after tx fell.
- Back-to-back: push 0xA3, 0x0F, 0xFF on consecutive cycles → three frames with no idle gap between stop and next start. A loopback into the existing receiver yields A3,0F,FF in order.
- Full boundary: FIFO_DEPTH=4, hold valid for 6 bytes 0x01..0x06 while the first frame starts:
  - ready drops when 4 are queued beyond the one popped.
  - Upstream holding data delivers all 6 in order, none lost or duplicated.
- STOP_BITS=2, byte 0x00 → start plus 8 zero bits = 9*DIV low, then tx high for exactly 2*DIV before the next queued start.
- Reset mid-frame: assert rst during data bit 3 of 0xC3 with 2 bytes queued → tx=1 asynchronously, busy=0, ready=1. After release, nothing is transmitted.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants, FSM state encoding and the
// clocks-per-bit helper used by both the transmitter and the receiver.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;

    // FSM state encoding shared by the tx and rx state machines
    typedef logic [1:0] uart_state_t;

    localparam uart_state_t ST_IDLE  = 2'd0;
    localparam uart_state_t ST_START = 2'd1;
    localparam uart_state_t ST_DATA  = 2'd2;
    localparam uart_state_t ST_STOP  = 2'd3;

    // Clocks per bit; integer divide, remainder is dropped
    function automatic int unsigned uart_div(input int unsigned clk_hz,
                                             input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO in front of the transmitter. Pointers carry one
// extra wrap bit so full and empty are distinguishable at any depth.
module uart_tx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Status flags and the head-of-queue read port
    always_comb begin
        empty     = (r_wr_ptr == r_rd_ptr);
        full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
        w_do_push = push && !full;
        w_do_pop  = pop && !empty;
        dout      = r_mem[r_rd_ptr[AW-1:0]];
    end

    // Storage; contents need no reset since the pointers define validity
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= din;
        end
    end

    // Pointer update; push and pop on the same edge both take effect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + (AW + 1)'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8N1 or 8N2, LSB first. Bytes enter through a
// valid/ready FIFO and are serialised at CLK_HZ/BAUD clocks per bit.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [UART_DATA_BITS-1:0] data,
    input  logic                      valid,
    output logic                      ready,
    output logic                      tx,
    output logic                      busy
);

    localparam int unsigned DIV       = uart_div(CLK_HZ, BAUD);
    localparam int unsigned CW        = (DIV >= 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    generate
        if (DIV < 2) begin : g_bad_div
            $error("uart_tx: CLK_HZ/BAUD must be at least 2");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
            $error("uart_tx: STOP_BITS must be 1 or 2");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("uart_tx: FIFO_DEPTH must be a power of two >= 2");
        end
    endgenerate

    uart_state_t               r_state;
    logic                      r_tx;
    logic [CW-1:0]             r_cnt;
    logic [UART_DATA_BITS-1:0] r_sh;
    logic [2:0]                r_bitp;
    logic                      r_stopn;

    logic                      w_full;
    logic                      w_empty;
    logic [UART_DATA_BITS-1:0] w_dout;
    logic                      w_bit_end;
    logic                      w_pop;

    uart_tx_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (valid),
        .pop   (w_pop),
        .din   (data),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty)
    );

    // Pop when idle, or when the final stop bit ends, so frames run back-to-back
    always_comb begin
        w_bit_end = (r_cnt == '0);
        w_pop     = !w_empty &&
                    ((r_state == ST_IDLE) ||
                     ((r_state == ST_STOP) && w_bit_end && (r_stopn == STOP_LAST)));
        ready     = !w_full;
        busy      = (r_state != ST_IDLE) || !w_empty;
        tx        = r_tx;
    end

    // Frame FSM with per-bit baud counter reloaded on every bit boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_tx    <= 1'b1;
            r_cnt   <= '0;
            r_sh    <= '0;
            r_bitp  <= '0;
            r_stopn <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_sh    <= w_dout;
                        r_tx    <= 1'b0;
                        r_cnt   <= CNT_LOAD;
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_bit_end) begin
                        r_tx    <= r_sh[0];
                        r_sh    <= {1'b0, r_sh[UART_DATA_BITS-1:1]};
                        r_bitp  <= 3'd0;
                        r_cnt   <= CNT_LOAD;
                        r_state <= ST_DATA;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= CNT_LOAD;
                        if (r_bitp == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_stopn <= 1'b0;
                            r_state <= ST_STOP;
                        end else begin
                            r_tx   <= r_sh[0];
                            r_sh   <= {1'b0, r_sh[UART_DATA_BITS-1:1]};
                            r_bitp <= r_bitp + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                ST_STOP: begin
                    if (w_bit_end) begin
                        if (r_stopn != STOP_LAST) begin
                            r_stopn <= 1'b1;
                            r_cnt   <= CNT_LOAD;
                        end else if (w_pop) begin
                            r_sh    <= w_dout;
                            r_tx    <= 1'b0;
                            r_cnt   <= CNT_LOAD;
                            r_state <= ST_START;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: DUT0 at default parameters (DIV=434, 1 stop bit),
// DUT1 with DIV=10 and 2 stop bits. A serial monitor per DUT decodes frames
// and compares them against a queue of expected bytes.
module tb_uart_tx;

    localparam int DIV0 = 434;
    localparam int SB0  = 1;
    localparam int DIV1 = 10;
    localparam int SB1  = 2;

    logic       clk = 1'b0;
    logic       rst0, rst1;
    logic [7:0] data0, data1;
    logic       valid0, valid1;
    logic       ready0, ready1;
    logic       tx0, tx1;
    logic       busy0, busy1;

    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         nframes0 = 0;
    int         nframes1 = 0;
    logic [7:0] exp0[$];
    logic [7:0] exp1[$];
    int         starts0[$];
    int         starts1[$];

    uart_tx u_dut0 (
        .clk   (clk),
        .rst   (rst0),
        .data  (data0),
        .valid (valid0),
        .ready (ready0),
        .tx    (tx0),
        .busy  (busy0)
    );

    uart_tx #(
        .CLK_HZ     (1000),
        .BAUD       (100),
        .STOP_BITS  (2),
        .FIFO_DEPTH (4)
    ) u_dut1 (
        .clk   (clk),
        .rst   (rst1),
        .data  (data1),
        .valid (valid1),
        .ready (ready1),
        .tx    (tx1),
        .busy  (busy1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic tx_of(input int id);
        return (id == 0) ? tx0 : tx1;
    endfunction

    function automatic logic rst_of(input int id);
        return (id == 0) ? rst0 : rst1;
    endfunction

    // Samples every clock of a frame and checks the exact waveform plus the
    // mid-bit decoded byte against the next expected entry.
    task automatic run_monitor(input int id, input int div, input int sb);
        int         n;
        logic [7:0] e;
        logic [7:0] got;
        logic [11:0] fr;
        logic       have, wave_ok, aborted, s;
        n = (9 + sb) * div;
        forever begin
            @(negedge clk);
            if (!rst_of(id) && tx_of(id) == 1'b0) begin
                if (id == 0) starts0.push_back(cyc);
                else starts1.push_back(cyc);
                have = (id == 0) ? (exp0.size() > 0) : (exp1.size() > 0);
                e = 8'h00;
                if (have) e = (id == 0) ? exp0.pop_front() : exp1.pop_front();
                fr = {3'b111, e, 1'b0};
                got = 8'h00;
                wave_ok = 1'b1;
                aborted = 1'b0;
                for (int k = 0; k < n; k++) begin
                    if (k > 0) @(negedge clk);
                    if (rst_of(id)) begin
                        aborted = 1'b1;
                        break;
                    end
                    s = tx_of(id);
                    if (s != fr[k / div]) wave_ok = 1'b0;
                    if ((k % div) == (div / 2) && (k / div) >= 1 && (k / div) <= 8)
                        got[(k / div) - 1] = s;
                end
                if (!aborted) begin
                    if (!have) begin
                        check($sformatf("unexpected_frame_dut%0d", id), got, -1);
                    end else begin
                        check($sformatf("frame_byte_dut%0d", id), got, e);
                        check($sformatf("frame_wave_dut%0d", id), wave_ok, 1);
                        if (id == 0) nframes0++;
                        else nframes1++;
                    end
                end
            end
        end
    endtask

    initial run_monitor(0, DIV0, SB0);
    initial run_monitor(1, DIV1, SB1);

    task automatic wait_idle(input int id, input int limit, input string name);
        int t = 0;
        while (((id == 0) ? busy0 : busy1) && t < limit) begin
            @(negedge clk);
            t++;
        end
        check({name, "_timeout"}, (t >= limit) ? 1 : 0, 0);
    endtask

    // Present a list of bytes on consecutive cycles; caller ensures room
    task automatic burst(input int id, input logic [7:0] b [$]);
        foreach (b[i]) begin
            if (id == 0) begin
                data0 = b[i]; valid0 = 1'b1; exp0.push_back(b[i]);
            end else begin
                data1 = b[i]; valid1 = 1'b1; exp1.push_back(b[i]);
            end
            @(negedge clk);
        end
        valid0 = 1'b0;
        valid1 = 1'b0;
    endtask

    initial begin
        int   acc, base, t, bad, accepted, full_seen, s0, nf;
        logic w;
        logic [7:0] q [$];

        rst0 = 1'b1; rst1 = 1'b1;
        valid0 = 1'b0; valid1 = 1'b0;
        data0 = 8'h00; data1 = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_tx", tx0, 1);
        check("reset_busy", busy0, 0);
        check("reset_ready", ready0, 1);
        rst0 = 1'b0; rst1 = 1'b0;

        // Idle after reset
        bad = 0;
        repeat (2000) begin
            @(negedge clk);
            if (tx0 !== 1'b1 || busy0 !== 1'b0 || ready0 !== 1'b1) bad++;
        end
        check("idle_cycles_bad", bad, 0);

        // Single byte 0x55: latency and busy duration
        acc = cyc + 1;
        q = '{8'h55};
        burst(0, q);
        t = 0;
        while (starts0.size() == 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("start_seen_timeout", (starts0.size() == 0) ? 1 : 0, 0);
        if (starts0.size() > 0) check("start_latency", starts0[0] - acc, 1);
        wait_idle(0, 6000, "single");
        if (starts0.size() > 0) check("busy_fall", cyc - starts0[0], 10 * DIV0);

        // Back-to-back frames
        base = starts0.size();
        q = '{8'hA3, 8'h0F, 8'hFF};
        burst(0, q);
        wait_idle(0, 15000, "b2b");
        check("b2b_frames", starts0.size() - base, 3);
        if (starts0.size() == base + 3) begin
            check("b2b_gap1", starts0[base + 1] - starts0[base], 10 * DIV0);
            check("b2b_gap2", starts0[base + 2] - starts0[base + 1], 10 * DIV0);
        end

        // Full boundary: upstream holds each byte until accepted
        accepted = 0;
        full_seen = 0;
        t = 0;
        while (accepted < 6 && t < 20000) begin
            data0 = 8'(accepted + 1);
            valid0 = 1'b1;
            w = ready0;
            if (!w && !full_seen) begin
                full_seen = 1;
                check("full_at_count", accepted, 5);
            end
            @(posedge clk);
            if (w) begin
                exp0.push_back(8'(accepted + 1));
                accepted++;
            end
            @(negedge clk);
            t++;
        end
        valid0 = 1'b0;
        check("full_seen", full_seen, 1);
        check("full_accepted", accepted, 6);
        wait_idle(0, 30000, "full");
        check("dut0_frames", nframes0, 10);
        check("dut0_queue_left", exp0.size(), 0);

        // Two stop bits with a queued byte behind
        base = starts1.size();
        q = '{8'h00, 8'h5A};
        burst(1, q);
        wait_idle(1, 1000, "stop2");
        check("stop2_frames", starts1.size() - base, 2);
        if (starts1.size() == base + 2)
            check("stop2_gap", starts1[base + 1] - starts1[base], 11 * DIV1);

        // Reset mid-frame during data bit 3 of 0xC3
        base = starts1.size();
        q = '{8'hC3, 8'h11, 8'h22};
        burst(1, q);
        t = 0;
        while (starts1.size() == base && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("mid_start_timeout", (starts1.size() == base) ? 1 : 0, 0);
        s0 = (starts1.size() > base) ? starts1[base] : cyc;
        while (cyc < s0 + 4 * DIV1 + 3) @(negedge clk);
        #2 rst1 = 1'b1;
        #1;
        check("midrst_tx", tx1, 1);
        check("midrst_busy", busy1, 0);
        check("midrst_ready", ready1, 1);
        exp1.delete();
        nf = nframes1;
        // A write attempted during reset must be ignored
        @(negedge clk);
        data1 = 8'h77; valid1 = 1'b1;
        @(negedge clk);
        valid1 = 1'b0;
        @(negedge clk);
        rst1 = 1'b0;
        bad = 0;
        repeat (500) begin
            @(negedge clk);
            if (tx1 !== 1'b1 || busy1 !== 1'b0) bad++;
        end
        check("post_reset_quiet", bad, 0);
        check("post_reset_frames", nframes1, nf);
        check("dut1_frames", nframes1, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
